sr_req_arbiter: RTL and testbench

SR_REQ_ARBITER -- requirements
Module: sr_req_arbiter

---
 rtl/sr_req_arbiter_pkg.sv | 15 +
 rtl/sr_req_arbiter_t_ff_cell.sv | 19 +
 rtl/sr_req_arbiter.sv | 129 ++++++++++++
 tb/tb_sr_req_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_req_arbiter_pkg.sv
// Shared definitions for the SR request arbiter: FSM state encoding and
// default parameter values used by the arbiter and its testbench.
package sr_req_arbiter_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

endpackage : sr_req_arbiter_pkg

// File: rtl/sr_req_arbiter_t_ff_cell.sv
// Toggle flip-flop holding the shared flag; toggles on t, clears on reset.
module t_ff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule : t_ff_cell

// File: rtl/sr_req_arbiter.sv
// Round-robin arbiter giving N_REQ requesters set/reset access to one shared
// flag; each operation walks IDLE -> GRANT -> UPDATE -> ACK.
module sr_req_arbiter
    import sr_req_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] op,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] ack,
    output logic             busy,
    output logic             q,
    output logic             q_bar,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] pick;
    logic             pick_vld;
    logic             op_r;
    logic             t;
    logic             conflict;

    // Round-robin search starting one past the last served requester.
    always_comb begin
        int               idx_i;
        logic [PTR_W-1:0] idx;
        idx_i    = 0;
        idx      = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx_i = (int'(ptr) + i) % N_REQ;
            idx   = PTR_W'(idx_i);
            if (!pick_vld && req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    assign conflict = (|(req & op)) && (|(req & ~op));

    // NOTE: asynchronous active-low reset belongs in the sensitivity list so
    // the state clears without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        gnt       = '0;
        ack       = '0;
        t         = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                gnt[winner] = 1'b1;
                state_nxt   = req[winner] ? ST_UPDATE : ST_IDLE;
            end
            ST_UPDATE: begin
                gnt[winner] = 1'b1;
                // Toggle only when the requested value differs from q, so S
                // and R can never reach the flop together.
                t           = (op_r & ~q) | (~op_r & q);
                state_nxt   = ST_ACK;
            end
            ST_ACK: begin
                ack[winner] = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr          <= PTR_W'(N_REQ - 1);
            winner       <= '0;
            op_r         <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            if (state == ST_IDLE && pick_vld) begin
                winner <= pick;
            end
            if (state == ST_GRANT) begin
                op_r <= op[winner];
            end
            if (state == ST_ACK) begin
                ptr <= winner;
            end
            if (state == ST_IDLE && conflict && conflict_cnt != '1) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

    t_ff_cell u_flag (
        .clk (clk),
        .rst (rst),
        .t   (t),
        .q   (q)
    );

    assign q_bar = ~q;
    assign busy  = (state != ST_IDLE);

endmodule : sr_req_arbiter

// File: tb/tb_sr_req_arbiter.sv
// Self-checking bench for sr_req_arbiter: directed scenarios plus random
// traffic against a transaction-timeline reference model.
module tb_sr_req_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] op;
    logic [N-1:0] gnt;
    logic [N-1:0] ack;
    logic         busy;
    logic         q;
    logic         q_bar;
    logic [W-1:0] conflict_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: age = cycles since the winner was chosen (0 = idle).
    int   age;
    int   win;
    logic opv;
    logic m_q;
    int   m_ptr;
    int   m_cnt;

    sr_req_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .op           (op),
        .gnt          (gnt),
        .ack          (ack),
        .busy         (busy),
        .q            (q),
        .q_bar        (q_bar),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        age   = 0;
        win   = 0;
        opv   = 1'b0;
        m_q   = 1'b0;
        m_ptr = N - 1;
        m_cnt = 0;
    endtask

    // Advance the model with the inputs the coming edge will sample, then
    // clock the DUT and compare every output one time unit after the edge.
    task automatic tick();
        logic [N-1:0] one;
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_ack;
        one = 1;
        if (age == 0) begin
            if ((req & op) != 0 && (req & ~op) != 0 && m_cnt < 255) m_cnt++;
            if (req != 0) begin
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (req[idx]) begin
                        win = idx;
                        break;
                    end
                end
                age = 1;
            end
        end else if (age == 1) begin
            opv = op[win];
            age = req[win] ? 2 : 0;
        end else if (age == 2) begin
            m_q = opv;
            age = 3;
        end else begin
            m_ptr = win;
            age   = 0;
        end
        @(posedge clk);
        #1;
        e_gnt = (age == 1 || age == 2) ? (one << win) : '0;
        e_ack = (age == 3) ? (one << win) : '0;
        n_cmp++;
        if (gnt !== e_gnt) begin
            n_err++;
            $display("FAIL gnt @%0t: got %b want %b", $time, gnt, e_gnt);
        end
        n_cmp++;
        if (ack !== e_ack) begin
            n_err++;
            $display("FAIL ack @%0t: got %b want %b", $time, ack, e_ack);
        end
        n_cmp++;
        if (busy !== (age != 0)) begin
            n_err++;
            $display("FAIL busy @%0t: got %b want %b", $time, busy, age != 0);
        end
        n_cmp++;
        if (q !== m_q) begin
            n_err++;
            $display("FAIL q @%0t: got %b want %b", $time, q, m_q);
        end
        n_cmp++;
        if (q_bar !== ~m_q) begin
            n_err++;
            $display("FAIL q_bar @%0t: got %b want %b", $time, q_bar, ~m_q);
        end
        n_cmp++;
        if (conflict_cnt !== W'(m_cnt)) begin
            n_err++;
            $display("FAIL conflict_cnt @%0t: got %0d want %0d", $time, conflict_cnt, m_cnt);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        req = '0;
        op  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 4'b1111;
        op  = 4'($urandom);
        model_reset();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end else begin
                #1;
            end
            n_cmp++;
            if (q !== 1'b0 || q_bar !== 1'b1) begin
                n_err++;
                $display("FAIL reset_q: got q=%b q_bar=%b want 0/1", q, q_bar);
            end
            n_cmp++;
            if (gnt !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_ctl: got gnt=%b ack=%b busy=%b want 0000/0000/0", gnt, ack, busy);
            end
            n_cmp++;
            if (conflict_cnt !== 8'd0) begin
                n_err++;
                $display("FAIL reset_cnt: got %0d want 0", conflict_cnt);
            end
        end
        req = '0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_set();
        apply_reset();
        req = 4'b0100;
        op  = 4'b0100;
        tick();
        n_cmp++;
        if (gnt !== 4'b0100) begin
            n_err++;
            $display("FAIL set_gnt1: got %b want 0100", gnt);
        end
        tick();
        n_cmp++;
        if (gnt !== 4'b0100 || ack !== 4'b0000) begin
            n_err++;
            $display("FAIL set_gnt2: got gnt=%b ack=%b want 0100/0000", gnt, ack);
        end
        tick();
        n_cmp++;
        if (q !== 1'b1 || ack !== 4'b0100 || gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL set_ack: got q=%b ack=%b gnt=%b want 1/0100/0000", q, ack, gnt);
        end
        req = '0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || q !== 1'b1) begin
            n_err++;
            $display("FAIL set_done: got busy=%b q=%b want 0/1", busy, q);
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int when[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        req = 4'b1111;
        op  = 4'b0101;
        for (int c = 1; c <= 20; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    order.push_back(i);
                    when.push_back(c);
                end
            end
        end
        req = '0;
        n_cmp++;
        if (order.size() < 5) begin
            n_err++;
            $display("FAIL rr_count: got %0d acks want 5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (order[i] != exp_order[i]) begin
                    n_err++;
                    $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], exp_order[i]);
                end
                if (i > 0) begin
                    n_cmp++;
                    if (when[i] - when[i-1] != 4) begin
                        n_err++;
                        $display("FAIL rr_spacing[%0d]: got %0d want 4", i, when[i] - when[i-1]);
                    end
                end
            end
        end
        tick();
    endtask

    task automatic test_conflict();
        apply_reset();
        req = 4'b0011;
        op  = 4'b0001;
        repeat (12) tick();
        n_cmp++;
        if (conflict_cnt !== 8'd3) begin
            n_err++;
            $display("FAIL conflict_3: got %0d want 3", conflict_cnt);
        end
        repeat (1040) tick();
        n_cmp++;
        if (conflict_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL conflict_sat: got %0d want 255", conflict_cnt);
        end
        req = '0;
        repeat (4) tick();
    endtask

    task automatic test_memory_withdraw();
        apply_reset();
        req = 4'b0001;
        op  = 4'b0000;
        repeat (3) tick();
        n_cmp++;
        if (ack !== 4'b0001 || q !== 1'b0) begin
            n_err++;
            $display("FAIL mem_reset: got ack=%b q=%b want 0001/0", ack, q);
        end
        req = '0;
        tick();
        req = 4'b0010;
        op  = 4'b0010;
        tick();
        req = '0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || ack !== 4'b0000 || q !== 1'b0) begin
            n_err++;
            $display("FAIL withdraw: got busy=%b ack=%b q=%b want 0/0000/0", busy, ack, q);
        end
        req = 4'b0110;
        op  = 4'b0110;
        tick();
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL withdraw_ptr: got %b want 0010", gnt);
        end
        tick();
        req = '0;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_op();
        // Reset while in UPDATE, then again while in ACK with q already set.
        for (int v = 0; v < 2; v++) begin
            apply_reset();
            req = 4'b0001;
            op  = 4'b0001;
            repeat (2 + v) tick();
            rst = 1'b0;
            #1;
            n_cmp++;
            if (q !== 1'b0 || q_bar !== 1'b1 || ack !== 4'b0000 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL midop_reset[%0d]: got q=%b q_bar=%b ack=%b busy=%b want 0/1/0000/0",
                         v, q, q_bar, ack, busy);
            end
            model_reset();
            req = '0;
            @(posedge clk);
            #1;
            rst = 1'b1;
            tick();
            n_cmp++;
            if (busy !== 1'b0 || ack !== 4'b0000 || q !== 1'b0) begin
                n_err++;
                $display("FAIL midop_after[%0d]: got busy=%b ack=%b q=%b want 0/0000/0", v, busy, ack, q);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3, 0) == 0) req = 4'($urandom);
            if ($urandom_range(3, 0) == 0) op  = 4'($urandom);
            tick();
        end
        req = '0;
        repeat (4) tick();
    endtask

    initial begin
        rst = 1'b0;
        req = '0;
        op  = '0;
        test_reset();
        test_single_set();
        test_round_robin();
        test_conflict();
        test_memory_withdraw();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sr_req_arbiter
